// File: rtl/spi_master_if_if.sv
// Bus bundle for the SPI master: start/finish handshake, config word, data words and SPI pins.
// The master modport is the core's view; the slave modport is the view of whoever drives it.
interface spi_master_if_if #(
  parameter int SPI_MAX_WIDTH_LOG = 4
);
  localparam int W = 1 << SPI_MAX_WIDTH_LOG;

  logic                         spi_start;
  logic                         spi_finish;
  logic                         sck;
  logic                         cs;
  logic                         mosi;
  logic                         miso;
  logic                         config_req;
  logic [SPI_MAX_WIDTH_LOG+1:0] config_data;
  logic [W-1:0]                 din;
  logic [W-1:0]                 dout;

  modport master (
    input  spi_start, miso, config_req, config_data, din,
    output spi_finish, sck, cs, mosi, dout
  );

  modport slave (
    output spi_start, miso, config_req, config_data, din,
    input  spi_finish, sck, cs, mosi, dout
  );
endinterface

// File: rtl/spi_master_if.sv
// SPI master with runtime CPOL/CPHA/word length; SCK is clk divided by 2^SPI_SCAIL_LOG.
// Define SPI_LSB_FIRST_EN to shift LSB first instead of MSB first.
module spi_master_if #(
  parameter int SPI_MAX_WIDTH_LOG = 4,
  parameter int SPI_SCAIL_LOG     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_if_if.master   bus
);
  localparam int W  = 1 << SPI_MAX_WIDTH_LOG;
  localparam int LW = SPI_MAX_WIDTH_LOG;
  localparam int CW = SPI_SCAIL_LOG - 1;
  localparam int EW = SPI_MAX_WIDTH_LOG + 2;

`ifdef SPI_LSB_FIRST_EN
  localparam logic LSB_FIRST = 1'b1;
`else
  localparam logic LSB_FIRST = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t          state_q;
  logic            cpol_q, cpha_q;
  logic [LW-1:0]   len_q;
  logic [W-1:0]    txData_q, rxData_q, dout_q;
  logic [CW-1:0]   divCnt_q;
  logic [EW-1:0]   edgeCnt_q;
  logic [LW-1:0]   txIdx_q, rxIdx_q;
  logic            sck_q, cs_q, mosi_q, finish_q;

  logic            cpol_d, cpha_d;
  logic [LW-1:0]   len_d;
  logic [LW-1:0]   firstIdx;
  logic            divDone, oddEdge, lastEdge, sampleEdge, driveEdge;

  function automatic logic [LW-1:0] stepIdx(input logic [LW-1:0] idx);
    return LSB_FIRST ? idx + 1'b1 : idx - 1'b1;
  endfunction

  // A config_req arriving with spi_start must already apply to that transfer.
  always_comb begin
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    len_d  = len_q;
    if (bus.config_req) begin
      cpol_d = bus.config_data[LW+1];
      cpha_d = bus.config_data[LW];
      len_d  = bus.config_data[LW-1:0];
    end
    firstIdx = LSB_FIRST ? '0 : len_d;
  end

  assign divDone    = (divCnt_q == '1);
  assign oddEdge    = ~edgeCnt_q[0];
  assign lastEdge   = (edgeCnt_q == {1'b0, len_q, 1'b1});
  assign sampleEdge = cpha_q ? ~oddEdge : oddEdge;
  assign driveEdge  = cpha_q ? oddEdge : (~oddEdge & ~lastEdge);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      len_q     <= '1;
      txData_q  <= '0;
      rxData_q  <= '0;
      dout_q    <= '0;
      divCnt_q  <= '0;
      edgeCnt_q <= '0;
      txIdx_q   <= '0;
      rxIdx_q   <= '0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cpol_q <= cpol_d;
          cpha_q <= cpha_d;
          len_q  <= len_d;
          sck_q  <= cpol_d;
          if (bus.spi_start) begin
            state_q   <= LEAD;
            cs_q      <= 1'b0;
            txData_q  <= bus.din;
            rxData_q  <= '0;
            divCnt_q  <= '0;
            edgeCnt_q <= '0;
            rxIdx_q   <= firstIdx;
            // With CPHA=0 the first bit is already on the wire when cs falls.
            mosi_q    <= cpha_d ? 1'b0 : bus.din[firstIdx];
            txIdx_q   <= cpha_d ? firstIdx : stepIdx(firstIdx);
          end
        end
        LEAD, SHIFT: begin
          divCnt_q <= divCnt_q + 1'b1;
          if (divDone) begin
            sck_q     <= ~sck_q;
            edgeCnt_q <= edgeCnt_q + 1'b1;
            if (sampleEdge) begin
              rxData_q[rxIdx_q] <= bus.miso;
              rxIdx_q           <= stepIdx(rxIdx_q);
            end
            if (driveEdge) begin
              mosi_q  <= txData_q[txIdx_q];
              txIdx_q <= stepIdx(txIdx_q);
            end
            state_q <= lastEdge ? TRAIL : SHIFT;
          end
        end
        TRAIL: begin
          divCnt_q <= divCnt_q + 1'b1;
          if (divDone) begin
            state_q  <= IDLE;
            cs_q     <= 1'b1;
            finish_q <= 1'b1;
            dout_q   <= rxData_q;
            mosi_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sck        = sck_q;
  assign bus.cs         = cs_q;
  assign bus.mosi       = mosi_q;
  assign bus.spi_finish = finish_q;
  assign bus.dout       = dout_q;
endmodule

// File: tb/tb_spi_master_if.sv
// Self-checking bench for spi_master_if: directed mode tests plus random loopback
// against a behavioural SPI slave model kept in this file.
module tb_spi_master_if;
  localparam int LOGW  = 4;
  localparam int W     = 1 << LOGW;
  localparam int SCAIL = 4;
  localparam int H     = 1 << (SCAIL - 1);

  logic clk;
  logic rst_n;

  spi_master_if_if #(.SPI_MAX_WIDTH_LOG(LOGW)) bus ();

  spi_master_if #(.SPI_MAX_WIDTH_LOG(LOGW), .SPI_SCAIL_LOG(SCAIL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Expected config register contents of the master
  bit refCpol = 1'b0;
  bit refCpha = 1'b0;
  int refN    = W;

  // Slave model state
  logic [W-1:0] slvTx = '0;
  logic [W-1:0] slvRx = '0;
  bit   slvCpol, slvCpha;
  int   slvN = W;
  int   slvEdges = 0;
  int   badMosi = 0;
  int   sckBad = 0;
  int   finishCount = 0;
  int   csFallCyc = 0;
  int   csRiseCyc = 0;
  logic prevCs = 1'b1;
  logic prevSck = 1'b0;
  logic prevMosi = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Position in the word of the k-th bit on the wire (k counts from 0)
  function automatic int bitPos(input int k, input int n);
`ifdef SPI_LSB_FIRST_EN
    return k;
`else
    return n - 1 - k;
`endif
  endfunction

  // Behavioural SPI slave: reacts to cs/sck changes seen at each falling clk edge
  initial begin
    int  e;
    bit  odd, masterDrives;
    forever begin
      @(negedge clk);
      if (bus.spi_finish === 1'b1) finishCount++;
      if (prevCs === 1'b1 && bus.cs === 1'b0) begin
        csFallCyc = cyc;
        slvCpol   = refCpol;
        slvCpha   = refCpha;
        slvN      = refN;
        slvEdges  = 0;
        slvRx     = '0;
        if (!slvCpha) bus.miso = slvTx[bitPos(0, slvN)];
      end else if (prevCs === 1'b0 && bus.cs === 1'b0) begin
        if (bus.sck !== prevSck) begin
          slvEdges++;
          e   = slvEdges;
          odd = (e % 2) == 1;
          if (odd && bus.sck === slvCpol) sckBad++;
          if (!odd && bus.sck !== slvCpol) sckBad++;
          masterDrives = slvCpha ? odd : (!odd && e != 2 * slvN);
          if (bus.mosi !== prevMosi && !masterDrives) badMosi++;
          if (slvCpha ? !odd : odd) slvRx[bitPos((e + 1) / 2 - 1, slvN)] = bus.mosi;
          if (!slvCpha && !odd && e < 2 * slvN) bus.miso = slvTx[bitPos(e / 2, slvN)];
          if (slvCpha && odd) bus.miso = slvTx[bitPos((e - 1) / 2, slvN)];
        end else if (bus.mosi !== prevMosi) begin
          badMosi++;
        end
      end else if (prevCs === 1'b0 && bus.cs === 1'b1) begin
        csRiseCyc = cyc;
      end
      prevCs   = bus.cs;
      prevSck  = bus.sck;
      prevMosi = bus.mosi;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic loadConfig(input logic [5:0] cfg);
    @(negedge clk);
    bus.config_req  = 1'b1;
    bus.config_data = cfg;
    refCpol = cfg[5];
    refCpha = cfg[4];
    refN    = int'(cfg[3:0]) + 1;
    @(negedge clk);
    bus.config_req = 1'b0;
    @(negedge clk);
  endtask

  // One complete transfer; optionally loads config with the start and pokes the busy master
  task automatic applyStimulus(input bit loadCfg, input logic [5:0] cfg,
                               input logic [W-1:0] dinWord, input logic [W-1:0] txWord,
                               input bit busyPoke, input string tag);
    int startCyc, finCyc, fc0, bm0, sb0, span;
    bit seen;
    logic [W-1:0] mask;
    @(negedge clk);
    if (loadCfg) begin
      refCpol = cfg[5];
      refCpha = cfg[4];
      refN    = int'(cfg[3:0]) + 1;
    end
    slvTx = txWord;
    fc0 = finishCount;
    bm0 = badMosi;
    sb0 = sckBad;
    bus.config_req  = loadCfg;
    bus.config_data = cfg;
    bus.din         = dinWord;
    bus.spi_start   = 1'b1;
    @(negedge clk);
    bus.spi_start  = 1'b0;
    bus.config_req = 1'b0;
    startCyc = cyc;
    if (busyPoke) begin
      repeat (H * 5) @(negedge clk);
      bus.spi_start   = 1'b1;
      bus.config_req  = 1'b1;
      bus.config_data = 6'b00_0011;
      bus.din         = ~dinWord;
      @(negedge clk);
      bus.spi_start  = 1'b0;
      bus.config_req = 1'b0;
    end
    seen = 1'b0;
    finCyc = 0;
    for (int i = 0; i < H * (2 * W + 6); i++) begin
      if (bus.spi_finish === 1'b1) begin
        seen = 1'b1;
        finCyc = cyc;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, ":finishSeen"}, 32'(seen), 32'd1);
    checkOutput({tag, ":csHighAtFinish"}, 32'(bus.cs), 32'd1);
    repeat (3) @(negedge clk);
    mask = '0;
    for (int i = 0; i < refN; i++) mask[i] = 1'b1;
    span = H * (2 * refN + 1);
    checkOutput({tag, ":finishTime"}, 32'(finCyc - startCyc), 32'(span));
    checkOutput({tag, ":csLowCycles"}, 32'(csRiseCyc - csFallCyc), 32'(span));
    checkOutput({tag, ":dout"}, 32'(bus.dout), 32'(txWord & mask));
    checkOutput({tag, ":slaveRx"}, 32'(slvRx), 32'(dinWord & mask));
    checkOutput({tag, ":sckEdges"}, 32'(slvEdges), 32'(2 * refN));
    checkOutput({tag, ":mosiTiming"}, 32'(badMosi - bm0), 32'd0);
    checkOutput({tag, ":sckDirection"}, 32'(sckBad - sb0), 32'd0);
    checkOutput({tag, ":finishPulses"}, 32'(finishCount - fc0), 32'd1);
    checkOutput({tag, ":sckIdle"}, 32'(bus.sck), 32'(refCpol));
    checkOutput({tag, ":mosiIdle"}, 32'(bus.mosi), 32'd0);
  endtask

  initial begin
    bit reached;
    rst_n           = 1'b0;
    bus.spi_start   = 1'b0;
    bus.config_req  = 1'b0;
    bus.config_data = '0;
    bus.din         = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset:cs", 32'(bus.cs), 32'd1);
    checkOutput("reset:sck", 32'(bus.sck), 32'd0);
    checkOutput("reset:mosi", 32'(bus.mosi), 32'd0);
    checkOutput("reset:finish", 32'(bus.spi_finish), 32'd0);
    checkOutput("reset:dout", 32'(bus.dout), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] mode 2, 16 bit");
    loadConfig(6'b10_1111);
    checkOutput("mode2:idleSck", 32'(bus.sck), 32'd1);
    applyStimulus(1'b0, 6'b10_1111, 16'hA5C3, 16'h3C5A, 1'b0, "mode2");

    $display("[TB] mode 0, 8 bit, config loaded with start");
    applyStimulus(1'b1, 6'b00_0111, 16'hFF12, 16'hFF9E, 1'b0, "mode0w8");

    $display("[TB] mode 3, 16 bit");
    applyStimulus(1'b1, 6'b11_1111, 16'h0001, 16'h8000, 1'b0, "mode3");

    $display("[TB] busy protection");
    applyStimulus(1'b1, 6'b01_1011, 16'h6B2D, 16'h0F31, 1'b1, "busy");
    applyStimulus(1'b0, 6'b00_0000, 16'hC7E4, 16'h5A19, 1'b0, "afterBusy");

    $display("[TB] reset mid-transfer");
    loadConfig(6'b00_1111);
    @(negedge clk);
    slvTx = 16'h1234;
    bus.din = 16'hBEEF;
    bus.spi_start = 1'b1;
    @(negedge clk);
    bus.spi_start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < H * 20; i++) begin
      @(negedge clk);
      if (slvEdges >= 5) begin
        reached = 1'b1;
        break;
      end
    end
    checkOutput("rstMid:edge5Reached", 32'(reached), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstMid:cs", 32'(bus.cs), 32'd1);
    checkOutput("rstMid:sck", 32'(bus.sck), 32'd0);
    checkOutput("rstMid:mosi", 32'(bus.mosi), 32'd0);
    checkOutput("rstMid:dout", 32'(bus.dout), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    refCpol = 1'b0;
    refCpha = 1'b0;
    refN    = W;
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 6'b00_0000, 16'h9D41, 16'h27C8, 1'b0, "postReset");

    $display("[TB] random loopback, mode 2, 16 bit");
    loadConfig(6'b10_1111);
    for (int t = 0; t < 100; t++) begin
      applyStimulus(1'b0, 6'b10_1111, W'($urandom), W'($urandom), 1'b0, "loop");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
